// File: rtl/cpu_stage_sequencer.sv
// TinyCPU multi-cycle stage sequencer: walks each instruction through fetch, memory read,
// register update, memory write and PC update, stalling on the memory handshake, with a
// wait watchdog, sticky halt/error and retired/stall counters.
module cpu_stage_sequencer #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [4:0]       current_instr_type,
  input  logic             mem_ready,
  input  logic             mem_write_ack,
  output logic [2:0]       stage,
  output logic             mem_read_req,
  output logic             instr_reg_load,
  output logic             load_data_latch,
  output logic             reg_write_en,
  output logic             pc_update,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] stall_cycles
);

  // Stage bus encodings shared with the memory controller and datapath.
  localparam logic [2:0] STAGE_INSTR_FETCH    = 3'd0;
  localparam logic [2:0] STAGE_MEMORY_READ    = 3'd1;
  localparam logic [2:0] STAGE_REGISTER_UPDATE = 3'd2;
  localparam logic [2:0] STAGE_MEMORY_WRITE   = 3'd3;
  localparam logic [2:0] STAGE_PC_UPDATE      = 3'd4;

  // Instruction type encodings from the decoder.
  localparam logic [4:0] INSTR_LOAD  = 5'd1;
  localparam logic [4:0] INSTR_STORE = 5'd2;
  localparam logic [4:0] INSTR_HALT  = 5'd3;

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    StFetch    = 3'd0,
    StMemRead  = 3'd1,
    StRegUpd   = 3'd2,
    StMemWrite = 3'd3,
    StPcUpd    = 3'd4,
    StHalt     = 3'd5,
    StError    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             waiting;

  logic is_load, is_store, is_halt;
  assign is_load  = (current_instr_type == INSTR_LOAD);
  assign is_store = (current_instr_type == INSTR_STORE);
  assign is_halt  = (current_instr_type == INSTR_HALT);

  // State, watchdog, sticky flags and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  // Next-state, strobes, watchdog and counter updates.
  always_comb begin
    state_d         = state_q;
    halted_d        = halted_q;
    error_d         = error_q;
    wait_d          = '0;
    waiting         = 1'b0;
    stage           = STAGE_INSTR_FETCH;
    mem_read_req    = 1'b0;
    instr_reg_load  = 1'b0;
    load_data_latch = 1'b0;
    reg_write_en    = 1'b0;
    pc_update       = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read_req = run;
        if (run) begin
          if (mem_ready) begin
            instr_reg_load = 1'b1;
            state_d        = StMemRead;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      StMemRead: begin
        stage = STAGE_MEMORY_READ;
        if (is_load) begin
          mem_read_req = 1'b1;
          if (mem_ready) begin
            load_data_latch = 1'b1;
            state_d         = StRegUpd;
          end else begin
            waiting = 1'b1;
          end
        end else begin
          state_d = StRegUpd;
        end
      end
      StRegUpd: begin
        stage        = STAGE_REGISTER_UPDATE;
        reg_write_en = !(is_store || is_halt);
        if (is_halt) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          state_d = StMemWrite;
        end
      end
      StMemWrite: begin
        // Stage must stay MEMORY_WRITE until ack: downstream write enable decodes it.
        stage = STAGE_MEMORY_WRITE;
        if (!is_store || mem_write_ack) state_d = StPcUpd;
        else                            waiting = 1'b1;
      end
      StPcUpd: begin
        stage     = STAGE_PC_UPDATE;
        pc_update = 1'b1;
        state_d   = StFetch;
      end
      StHalt, StError: begin
        state_d = state_q;
      end
      default: state_d = StFetch;
    endcase

    // A ready/ack in the final allowed cycle clears waiting, so it beats the timeout.
    if (waiting) begin
      if (wait_q == WaitW'(MAX_WAIT - 1)) begin
        state_d = StError;
        error_d = 1'b1;
      end else begin
        wait_d = wait_q + WaitW'(1);
      end
    end

    retired_d = pc_update ? retired_q + CNT_W'(1) : retired_q;
    stall_d   = (waiting && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;

    // Reset drops every request and strobe immediately, not at the next edge.
    if (rst) begin
      mem_read_req    = 1'b0;
      instr_reg_load  = 1'b0;
      load_data_latch = 1'b0;
      reg_write_en    = 1'b0;
      pc_update       = 1'b0;
    end
  end

  assign halted        = halted_q;
  assign error         = error_q;
  assign retired_count = retired_q;
  assign stall_cycles  = stall_q;

endmodule
